// File: rtl/register_ex_mem.sv
// EX/MEM pipeline register: captures Execute-stage datapath and control values
// each rising edge and presents them to the Memory stage one cycle later.
module register_ex_mem #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       ALUResultE,
  input  logic [XLEN-1:0]       WriteDataE,
  input  logic [XLEN-1:0]       PCPlus4E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic                  RegWriteE,
  input  logic [1:0]            ResultSrcE,
  input  logic                  MemWriteE,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [XLEN-1:0]       PCPlus4M,
  output logic [REG_ADDR_W-1:0] RdM,
  output logic                  RegWriteM,
  output logic [1:0]            ResultSrcM,
  output logic                  MemWriteM
);

  logic [XLEN-1:0]       r_alu_result;
  logic [XLEN-1:0]       r_write_data;
  logic [XLEN-1:0]       r_pc_plus4;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic [1:0]            r_result_src;
  logic                  r_mem_write;

  // Pipeline capture; reset wins and leaves a bubble (no register or memory write).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_result <= {XLEN{1'b0}};
      r_write_data <= {XLEN{1'b0}};
      r_pc_plus4   <= {XLEN{1'b0}};
      r_rd         <= {REG_ADDR_W{1'b0}};
      r_reg_write  <= 1'b0;
      r_result_src <= 2'b00;
      r_mem_write  <= 1'b0;
    end else begin
      r_alu_result <= ALUResultE;
      r_write_data <= WriteDataE;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= RdE;
      r_reg_write  <= RegWriteE;
      r_result_src <= ResultSrcE;
      r_mem_write  <= MemWriteE;
    end
  end

  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;
  assign RdM        = r_rd;
  assign RegWriteM  = r_reg_write;
  assign ResultSrcM = r_result_src;
  assign MemWriteM  = r_mem_write;

endmodule

// File: tb/tb_register_ex_mem.sv
// Table-driven bench for register_ex_mem plus hand-written sequences for
// mid-cycle input changes and a reset pulse that falls between clock edges.
module tb_register_ex_mem;

  logic        clk;
  logic        reset;
  logic [31:0] alu_e, wd_e, pc4_e;
  logic [4:0]  rd_e;
  logic        rw_e, mw_e;
  logic [1:0]  src_e;
  logic [31:0] alu_m, wd_m, pc4_m;
  logic [4:0]  rd_m;
  logic        rw_m, mw_m;
  logic [1:0]  src_m;

  int checks = 0;
  int errors = 0;

  register_ex_mem #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .ALUResultE(alu_e), .WriteDataE(wd_e), .PCPlus4E(pc4_e), .RdE(rd_e),
    .RegWriteE(rw_e), .ResultSrcE(src_e), .MemWriteE(mw_e),
    .ALUResultM(alu_m), .WriteDataM(wd_m), .PCPlus4M(pc4_m), .RdM(rd_m),
    .RegWriteM(rw_m), .ResultSrcM(src_m), .MemWriteM(mw_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] alu, wd, pc4;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  src;
    logic        mw;
    logic [31:0] x_alu, x_wd, x_pc4;
    logic [4:0]  x_rd;
    logic        x_rw;
    logic [1:0]  x_src;
    logic        x_mw;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] p, input logic [4:0] r, input logic rw,
                         input logic [1:0] s, input logic mw);
    chk({tag, ".ALUResultM"}, alu_m, a);
    chk({tag, ".WriteDataM"}, wd_m, w);
    chk({tag, ".PCPlus4M"}, pc4_m, p);
    chk({tag, ".RdM"}, {27'd0, rd_m}, {27'd0, r});
    chk({tag, ".RegWriteM"}, {31'd0, rw_m}, {31'd0, rw});
    chk({tag, ".ResultSrcM"}, {30'd0, src_m}, {30'd0, s});
    chk({tag, ".MemWriteM"}, {31'd0, mw_m}, {31'd0, mw});
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    alu_e = v.alu; wd_e = v.wd; pc4_e = v.pc4; rd_e = v.rd;
    rw_e = v.rw; src_e = v.src; mw_e = v.mw;
  endtask

  initial begin
    // rst, alu, wd, pc4, rd, rw, src, mw  |  expected M outputs
    vecs[0] = '{1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 5'd7,  1'b1, 2'b11, 1'b1,
                32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1, 2'b10, 1'b1,
                32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0};
    vecs[2] = '{1'b0, 32'h11112222, 32'h33334444, 32'h55556666, 5'd15, 1'b1, 2'b01, 1'b1,
                32'h11112222, 32'h33334444, 32'h55556666, 5'd15, 1'b1, 2'b01, 1'b1};
    vecs[3] = '{1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 5'd20, 1'b0, 2'b10, 1'b0,
                32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 5'd20, 1'b0, 2'b10, 1'b0};
    vecs[4] = '{1'b1, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 5'd20, 1'b0, 2'b10, 1'b0,
                32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0};
    vecs[5] = '{1'b0, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 5'd20, 1'b0, 2'b10, 1'b0,
                32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 5'd20, 1'b0, 2'b10, 1'b0};
    vecs[6] = '{1'b0, 32'hDEADBEEF, 32'hCAFEBABE, 32'hBAADF00D, 5'd31, 1'b1, 2'b11, 1'b1,
                32'hDEADBEEF, 32'hCAFEBABE, 32'hBAADF00D, 5'd31, 1'b1, 2'b11, 1'b1};
    vecs[7] = '{1'b0, 32'h00000001, 32'h80000000, 32'h7FFFFFFE, 5'd0,  1'b0, 2'b11, 1'b0,
                32'h00000001, 32'h80000000, 32'h7FFFFFFE, 5'd0,  1'b0, 2'b11, 1'b0};

    reset = 1'b0;
    alu_e = 32'h0; wd_e = 32'h0; pc4_e = 32'h0; rd_e = 5'd0;
    rw_e = 1'b0; src_e = 2'b00; mw_e = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      // New inputs must not show before the edge: outputs still hold the previous slot.
      if (i > 0)
        chk_all($sformatf("v%0d.hold", i), vecs[i-1].x_alu, vecs[i-1].x_wd, vecs[i-1].x_pc4,
                vecs[i-1].x_rd, vecs[i-1].x_rw, vecs[i-1].x_src, vecs[i-1].x_mw);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d.edge", i), vecs[i].x_alu, vecs[i].x_wd, vecs[i].x_pc4,
              vecs[i].x_rd, vecs[i].x_rw, vecs[i].x_src, vecs[i].x_mw);
    end

    // Inputs wiggle mid-cycle: outputs hold, then the value present at the edge is taken.
    @(negedge clk);
    alu_e = 32'h01020304; wd_e = 32'h05060708; pc4_e = 32'h090A0B0C; rd_e = 5'd3;
    rw_e = 1'b1; src_e = 2'b01; mw_e = 1'b1;
    #1;
    chk_all("midcyc.hold1", 32'h00000001, 32'h80000000, 32'h7FFFFFFE, 5'd0, 1'b0, 2'b11, 1'b0);
    #2;
    alu_e = 32'h13579BDF; wd_e = 32'h2468ACE0; pc4_e = 32'h00001004; rd_e = 5'd9;
    rw_e = 1'b1; src_e = 2'b00; mw_e = 1'b0;
    #1;
    chk_all("midcyc.hold2", 32'h00000001, 32'h80000000, 32'h7FFFFFFE, 5'd0, 1'b0, 2'b11, 1'b0);
    @(posedge clk);
    #1;
    chk_all("midcyc.edge", 32'h13579BDF, 32'h2468ACE0, 32'h00001004, 5'd9, 1'b1, 2'b00, 1'b0);

    // Reset pulsed high and low between edges is invisible to the register.
    @(negedge clk);
    reset = 1'b1;
    #2;
    chk_all("rstpulse.during", 32'h13579BDF, 32'h2468ACE0, 32'h00001004, 5'd9, 1'b1, 2'b00, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rstpulse.after", 32'h13579BDF, 32'h2468ACE0, 32'h00001004, 5'd9, 1'b1, 2'b00, 1'b0);

    // Reset raised just after an edge takes effect only at the following edge.
    reset = 1'b1;
    #2;
    chk_all("rstlate.before", 32'h13579BDF, 32'h2468ACE0, 32'h00001004, 5'd9, 1'b1, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chk_all("rstlate.edge", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rstlate.recap", 32'h13579BDF, 32'h2468ACE0, 32'h00001004, 5'd9, 1'b1, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
